// File: rtl/mul_clocked_multi.sv
// mul_clocked_multi: sequential shift-add multiplier, BITS_PER_CYCLE multiplier
// bits retired per MUL cycle, full 2*WIDTH-bit product as out_hi:out.
// Signed mode multiplies magnitudes and negates the product at the end.
// Optional feature macro: MUL_EARLY_EXIT_EN. When it is defined, the MUL phase
// ends as soon as the remaining multiplier bits are all zero.
module mul_clocked_multi #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             ack,
  output logic             busy
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  // Reject parameter sets the datapath cannot handle.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("mul_clocked_multi: WIDTH must be >= 2");
    end
    if ((BITS_PER_CYCLE < 1) || ((BITS_PER_CYCLE & (BITS_PER_CYCLE - 1)) != 0) ||
        ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_bpc
      $error("mul_clocked_multi: BITS_PER_CYCLE must be a power of two dividing WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [PW-1:0]      acc_reg;
  logic [PW-1:0]      a_shift_reg;   // |a| pre-shifted to the current chunk weight
  logic [WIDTH-1:0]   b_rem_reg;     // |b| with already-processed chunks shifted out
  logic [CNT_W-1:0]   cnt_reg;
  logic               neg_reg;
  logic [WIDTH-1:0]   out_reg;
  logic [WIDTH-1:0]   out_hi_reg;
  logic               ack_reg;
  logic               busy_reg;

  logic [WIDTH-1:0]          a_mag;
  logic [WIDTH-1:0]          b_mag;
  logic [BITS_PER_CYCLE-1:0] b_chunk;
  logic [PW-1:0]             pp [BITS_PER_CYCLE];
  logic [PW-1:0]             chunk_sum;
  logic [PW-1:0]             result;
  logic                      last_chunk;

  // Operand magnitudes; -2^(WIDTH-1) maps onto itself, which is the correct
  // unsigned magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  assign b_chunk = b_rem_reg[BITS_PER_CYCLE-1:0];

  // One partial product per multiplier bit of the current chunk.
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp[gi] = b_chunk[gi] ? (a_shift_reg << gi) : '0;
    end
  endgenerate

  // Sum the partial products of this chunk.
  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chunk_sum = chunk_sum + pp[i];
    end
  end

  assign result = neg_reg ? -acc_reg : acc_reg;

`ifdef MUL_EARLY_EXIT_EN
  logic b_rest_zero;
  // Nothing left above the current chunk: this is the last useful cycle.
  assign b_rest_zero = ((b_rem_reg >> BITS_PER_CYCLE) == '0);
  assign last_chunk  = (cnt_reg == LAST_CNT) || b_rest_zero;
`else
  assign last_chunk  = (cnt_reg == LAST_CNT);
`endif

  // Control FSM and datapath registers, including the registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      a_shift_reg <= '0;
      b_rem_reg   <= '0;
      cnt_reg     <= '0;
      neg_reg     <= 1'b0;
      out_reg     <= '0;
      out_hi_reg  <= '0;
      ack_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            a_shift_reg <= {{WIDTH{1'b0}}, a_mag};
            b_rem_reg   <= b_mag;
            neg_reg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= MUL;
          end
        end
        MUL: begin
          acc_reg     <= acc_reg + chunk_sum;
          a_shift_reg <= a_shift_reg << BITS_PER_CYCLE;
          b_rem_reg   <= b_rem_reg >> BITS_PER_CYCLE;
          cnt_reg     <= cnt_reg + CNT_W'(1);
          if (last_chunk) begin
            state_reg <= FIN;
          end
        end
        FIN: begin
          {out_hi_reg, out_reg} <= result;
          ack_reg               <= 1'b1;
          busy_reg              <= 1'b0;
          state_reg             <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign out    = out_reg;
  assign out_hi = out_hi_reg;
  assign ack    = ack_reg;
  assign busy   = busy_reg;

`ifndef SYNTHESIS
  // Unknown request while idle, or unknown captured operands while multiplying.
  assert_known_req : assert property (@(posedge clk) disable iff (!rst)
    (state_reg == IDLE) |-> !$isunknown(req));
  assert_known_ops : assert property (@(posedge clk) disable iff (!rst)
    (state_reg == MUL) |-> !$isunknown({a_shift_reg, b_rem_reg, neg_reg}));
`endif

endmodule
